wb_wport_arb: RTL and testbench
===============================

Name: wb_wport_arb

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback and a long-latency unit (LU: divider or load-miss return).
- The pipeline writeback always has priority and never waits.
- LU results queue in a small FIFO and drain into idle write-port cycles.
- Sits between the writeback stage, the LU and the regfile write interface. Requests a pipeline stall when the queue needs a slot.

Parameters:
DEPTH, 4, LU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive ungranted cycles with a live head before a forced stall (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wb_w_rd  in  1  pipeline writeback write enable (bubble already masked)
wb_rd  in  5  pipeline destination register
wb_res  in  32  pipeline result
lu_valid  in  1  LU result valid
lu_rd  in  5  LU destination register
lu_res  in  32  LU result
lu_ready  out  1  FIFO can accept an LU result
rf_w_rd  out  1  regfile write enable
rf_rd  out  5  regfile write index
rf_rd_val  out  32  regfile write data
stall_req  out  1  registered request to the hazard unit to inject one writeback bubble
pend_cnt  out  $clog2(DEPTH+1)  occupied FIFO slots, killed entries included

Behaviour:
- Reset (rst low, async):
  - FIFO empty; pend_cnt=0; stall_req=0; starvation counter=0.
  - rf_w_rd=0; lu_ready=1 once rst is high.
- lu_ready = (pend_cnt != DEPTH), combinational. No same-cycle enqueue when full, even if the head pops.
- Each FIFO entry holds {live, rd, res}.
- Port selection, combinational, priority order:
  1. wb_w_rd=1 -> port = wb_rd/wb_res.
  2. Else FIFO head live -> port = head, pop at posedge.
  3. Else FIFO empty (pend_cnt=0) and lu_valid -> bypass: port = lu_rd/lu_res. The entry is consumed and not enqueued.
  4. Else rf_w_rd=0.
- rd=0:
  - An LU handshake with lu_rd=0 is accepted and dropped: no enqueue, no write.
  - wb_rd=0 passes through unchanged.
- Enqueue: at posedge when lu_valid && lu_ready and neither bypassed nor dropped. Entry written at tail with live=1.
- Dead head: a head with live=0 pops at the next posedge with no port use, regardless of wb_w_rd. At most one pop per cycle.
- WAW kill: when wb_w_rd=1 and wb_rd!=0, every stored entry (present at the start of the cycle) whose rd==wb_rd gets live cleared at posedge.
  - A same-cycle incoming LU entry is not killed.
  - A head granted that cycle cannot also be killed: the grant requires wb_w_rd=0.
- pend_cnt: +1 on enqueue, -1 on pop, unchanged when both happen. Pointers wrap modulo DEPTH.
- stall_req (base): registered; set at posedge when next pend_cnt==DEPTH, cleared otherwise. Asserted one cycle after the FIFO fills.
- Simultaneous wb write, live head and lu_valid with FIFO non-full: wb wins the port, LU enqueues, head waits.
- rst asserted mid-operation: all queued results are discarded. rf_w_rd drops immediately (async).

Optional Feature:
- Macro WB_WPORT_STARVE_GUARD_EN.
- Defined:
  - A saturating counter increments each cycle the head is live and not granted. It resets to 0 on a head grant or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_req is set at that posedge.
  - stall_req stays high until the cycle after the head is granted.
  - stall_req is the OR of the full condition and the starvation condition.
- Undefined: no counter; stall_req reflects the full condition only.

Test Plan:
- Reset with lu_valid=1, wb_w_rd=1 held -> rf_w_rd=0 while rst low; after release: lu_ready=1, pend_cnt=0, stall_req=0.
- Idle pipeline, empty FIFO, lu_valid with rd=5, res=0xDEADBEEF -> same-cycle rf_w_rd=1, rf_rd=5, rf_rd_val=0xDEADBEEF; pend_cnt stays 0.
- wb_w_rd=1 every cycle and 4 LU results (rd 1..4) -> pend_cnt reaches 4, lu_ready=0, stall_req=1 next cycle. One wb bubble -> rd=1 written, pend_cnt=3, stall_req=0 following cycle.
- Queued entry rd=7, then wb write rd=7 res=0x11 -> entry killed. The next idle cycle pops it with rf_w_rd=0; the regfile keeps 0x11.
- LU result with lu_rd=0 -> lu_ready=1, no write, pend_cnt unchanged.
- With WB_WPORT_STARVE_GUARD_EN, STARVE_LIMIT=8, one live entry, wb_w_rd=1 continuously -> stall_req rises after 8 ungranted cycles. A single bubble grants the head, and stall_req falls the next cycle. Without the macro, stall_req stays 0 throughout.

Source files
------------

// File: rtl/wb_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency results queue and drain into idle cycles.
// Optional starvation guard enabled by defining WB_WPORT_STARVE_GUARD_EN.
module wb_wport_arb #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_w_rd,
    input  logic [4:0]                   wb_rd,
    input  logic [31:0]                  wb_res,
    input  logic                         lu_valid,
    input  logic [4:0]                   lu_rd,
    input  logic [31:0]                  lu_res,
    output logic                         lu_ready,
    output logic                         rf_w_rd,
    output logic [4:0]                   rf_rd,
    output logic [31:0]                  rf_rd_val,
    output logic                         stall_req,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          live_reg [DEPTH];
    logic [4:0]    rd_reg   [DEPTH];
    logic [31:0]   res_reg  [DEPTH];
    logic          stall_reg;

    logic fifo_empty;
    logic fifo_full;
    logic head_live;
    logic head_dead;
    logic grant_head;
    logic bypass;
    logic enq;
    logic pop;
    logic kill_en;
    logic starve_hit;

    assign fifo_empty = (cnt_reg == '0);
    assign fifo_full  = (cnt_reg == CW'(DEPTH));
    assign head_live  = !fifo_empty && live_reg[head_reg];
    assign head_dead  = !fifo_empty && !live_reg[head_reg];
    assign grant_head = !wb_w_rd && head_live;
    // Bypass only when nothing older is queued, so write order to the same rd is preserved.
    assign bypass     = !wb_w_rd && fifo_empty && lu_valid && (lu_rd != 5'd0);
    assign enq        = lu_valid && !fifo_full && !bypass && (lu_rd != 5'd0);
    assign pop        = grant_head || head_dead;
    assign kill_en    = wb_w_rd && (wb_rd != 5'd0);

    always_comb begin
        cnt_next = cnt_reg;
        if (enq && !pop) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (!enq && pop) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Outputs are gated by reset so the port goes quiet the moment rst falls.
    always_comb begin
        rf_w_rd   = 1'b0;
        rf_rd     = 5'd0;
        rf_rd_val = 32'd0;
        if (rst) begin
            if (wb_w_rd) begin
                rf_w_rd   = 1'b1;
                rf_rd     = wb_rd;
                rf_rd_val = wb_res;
            end else if (head_live) begin
                rf_w_rd   = 1'b1;
                rf_rd     = rd_reg[head_reg];
                rf_rd_val = res_reg[head_reg];
            end else if (bypass) begin
                rf_w_rd   = 1'b1;
                rf_rd     = lu_rd;
                rf_rd_val = lu_res;
            end
        end
    end

    assign lu_ready  = rst && !fifo_full;
    assign stall_req = stall_reg;
    assign pend_cnt  = cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            cnt_reg   <= '0;
            stall_reg <= 1'b0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + AW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + AW'(1);
            end
            cnt_reg   <= cnt_next;
            stall_reg <= (cnt_next == CW'(DEPTH)) || starve_hit;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_reg[tail_reg]  <= lu_rd;
            res_reg[tail_reg] <= lu_res;
        end
    end

    // A fresh enqueue into a slot overrides a kill aimed at that slot's stale rd.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    live_reg[gi] <= 1'b0;
                end else if (enq && (tail_reg == AW'(gi))) begin
                    live_reg[gi] <= 1'b1;
                end else if (kill_en && (rd_reg[gi] == wb_rd)) begin
                    live_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef WB_WPORT_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_reg;
    logic [SW-1:0] starve_next;

    always_comb begin
        starve_next = starve_reg;
        if (grant_head || fifo_empty) begin
            starve_next = '0;
        end else if (head_live && (starve_reg != SW'(STARVE_LIMIT))) begin
            starve_next = starve_reg + SW'(1);
        end
    end

    assign starve_hit = (starve_next == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    // Guard compiled out: the limit only appears in a never-true expression.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_wb_wport_arb.sv
// Randomized and directed bench for wb_wport_arb against a queue-based behavioural model.
// Honours WB_WPORT_STARVE_GUARD_EN the same way the design does.
module tb_wb_wport_arb;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_w_rd = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_res = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_res = 32'd0;
    logic        lu_ready;
    logic        rf_w_rd;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_val;
    logic        stall_req;
    logic [2:0]  pend_cnt;

    always #5 clk = ~clk;

    wb_wport_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .wb_res(wb_res),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_res(lu_res),
        .lu_ready(lu_ready), .rf_w_rd(rf_w_rd), .rf_rd(rf_rd), .rf_rd_val(rf_rd_val),
        .stall_req(stall_req), .pend_cnt(pend_cnt)
    );

    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [31:0] res;
    } ent_t;

    ent_t        q[$];
    bit          m_stall = 1'b0;
    int          starve = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] seen_rf [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare against the model at the falling edge, then advance the model.
    task automatic step(input bit wbw, input bit [4:0] wrd, input bit [31:0] wres,
                        input bit lv, input bit [4:0] lrd, input bit [31:0] lres);
        bit        exp_w;
        bit [4:0]  exp_rd;
        bit [31:0] exp_val;
        int        pre;
        bit        hlive, grant, pop, byp, push;
        @(posedge clk);
        #1;
        wb_w_rd = wbw; wb_rd = wrd; wb_res = wres;
        lu_valid = lv; lu_rd = lrd; lu_res = lres;
        @(negedge clk);

        pre   = q.size();
        hlive = (pre > 0) && q[0].live;
        byp   = !wbw && (pre == 0) && lv && (lrd != 5'd0);
        exp_w = 1'b0; exp_rd = 5'd0; exp_val = 32'd0;
        if (wbw) begin
            exp_w = 1'b1; exp_rd = wrd; exp_val = wres;
        end else if (hlive) begin
            exp_w = 1'b1; exp_rd = q[0].rd; exp_val = q[0].res;
        end else if (byp) begin
            exp_w = 1'b1; exp_rd = lrd; exp_val = lres;
        end
        check("lu_ready", 32'(lu_ready), 32'(pre != DEPTH));
        check("pend_cnt", 32'(pend_cnt), 32'(pre));
        check("stall_req", 32'(stall_req), 32'(m_stall));
        check("rf_w_rd", 32'(rf_w_rd), 32'(exp_w));
        if (exp_w) begin
            check("rf_rd", 32'(rf_rd), 32'(exp_rd));
            check("rf_rd_val", rf_rd_val, exp_val);
        end
        if (rf_w_rd === 1'b1) begin
            seen_rf[rf_rd] = rf_rd_val;
            $display("t=%0t write rd=%0d val=%h pend=%0d", $time, rf_rd, rf_rd_val, pend_cnt);
        end

        grant = !wbw && hlive;
        pop   = (pre > 0) && (grant || !q[0].live);
        push  = lv && (pre != DEPTH) && !byp && (lrd != 5'd0);
        if (wbw && wrd != 5'd0) begin
            foreach (q[i]) if (q[i].rd == wrd) q[i].live = 1'b0;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{1'b1, lrd, lres});
        m_stall = (q.size() == DEPTH);
`ifdef WB_WPORT_STARVE_GUARD_EN
        if (grant || pre == 0) starve = 0;
        else if (hlive && starve < LIMIT) starve++;
        if (starve >= LIMIT) m_stall = 1'b1;
`endif
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bit guard;
`ifdef WB_WPORT_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        foreach (seen_rf[i]) seen_rf[i] = 32'd0;

        // Reset held with both requesters active: port must stay quiet.
        rst = 1'b0; wb_w_rd = 1'b1; wb_rd = 5'd4; lu_valid = 1'b1; lu_rd = 5'd3;
        repeat (3) begin
            @(negedge clk);
            check("rst_rf_w_rd", 32'(rf_w_rd), 32'd0);
        end
        @(posedge clk);
        #2;
        wb_w_rd = 1'b0; lu_valid = 1'b0; rst = 1'b1;
        idle();
        check("post_rst_ready", 32'(lu_ready), 32'd1);
        check("post_rst_pend", 32'(pend_cnt), 32'd0);
        check("post_rst_stall", 32'(stall_req), 32'd0);

        // Bypass into an idle port.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("byp_w", 32'(rf_w_rd), 32'd1);
        check("byp_rd", 32'(rf_rd), 32'd5);
        check("byp_val", rf_rd_val, 32'hDEADBEEF);
        idle();
        check("byp_pend", 32'(pend_cnt), 32'd0);

        // Fill the FIFO behind a busy pipeline.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(i + 1), 32'(200 + i));
        step(1'b1, 5'd14, 32'd104, 1'b0, 5'd0, 32'd0);
        check("full_pend", 32'(pend_cnt), 32'd4);
        check("full_ready", 32'(lu_ready), 32'd0);
        check("full_stall", 32'(stall_req), 32'd1);
        idle();
        check("bubble_rd", 32'(rf_rd), 32'd1);
        check("bubble_val", rf_rd_val, 32'd200);
        step(1'b1, 5'd15, 32'd105, 1'b0, 5'd0, 32'd0);
        check("after_pend", 32'(pend_cnt), 32'd3);
        check("after_stall", 32'(stall_req), 32'd0);
        repeat (4) idle();

        // WAW kill of a queued rd=7 entry.
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'h77);
        step(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0);
        idle();
        check("kill_no_write", 32'(rf_w_rd), 32'd0);
        check("kill_pend", 32'(pend_cnt), 32'd1);
        idle();
        check("kill_popped", 32'(pend_cnt), 32'd0);
        check("kill_rf7", seen_rf[7], 32'h11);

        // rd=0 LU results are accepted and dropped.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        check("rd0_ready", 32'(lu_ready), 32'd1);
        check("rd0_no_write", 32'(rf_w_rd), 32'd0);
        idle();
        check("rd0_pend", 32'(pend_cnt), 32'd0);

        // One live entry starved by a continuously busy pipeline.
        step(1'b1, 5'd20, 32'd0, 1'b1, 5'd9, 32'h99);
        for (int j = 1; j <= 10; j++) begin
            step(1'b1, 5'd21, 32'(j), 1'b0, 5'd0, 32'd0);
            check("starve_stall", 32'(stall_req), 32'(guard && j >= 9));
        end
        idle();
        check("starve_grant_rd", 32'(rf_rd), 32'd9);
        idle();
        check("starve_release", 32'(stall_req), 32'd0);
        check("starve_pend", 32'(pend_cnt), 32'd0);

        // Randomized traffic with alternating pipeline density.
        for (int c = 0; c < 2000; c++) begin
            bit dense;
            dense = ((c / 150) % 2) == 0;
            step(dense ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        // Reset in the middle of traffic.
        step(1'b1, 5'd12, 32'd1, 1'b1, 5'd6, 32'd2);
        @(posedge clk);
        #1;
        wb_w_rd = 1'b1; lu_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_rf_w_rd", 32'(rf_w_rd), 32'd0);
        check("midrst_pend", 32'(pend_cnt), 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        q.delete();
        m_stall = 1'b0;
        starve = 0;
        @(posedge clk);
        #2;
        wb_w_rd = 1'b0; lu_valid = 1'b0; rst = 1'b1;
        idle();
        idle();
        check("midrst_ready", 32'(lu_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
